dm_sized: RTL and testbench



---
 rtl/dm_pkg.sv | 27 ++
 rtl/dm_byte_lane.sv | 73 +++++++
 rtl/dm_sized.sv | 140 ++++++++++++++
 tb/tb_dm_sized.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the sized data memory.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } dm_state_t;

  // 1 when the access cannot be performed: reserved size or lanes crossing the natural boundary.
  function automatic logic dm_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_byte_lane.sv
// Combinational lane steering: merges store data into a word and extracts/extends load data.
module dm_byte_lane
  import dm_pkg::*;
(
  input  logic [31:0] word_old,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        uns,
  output logic [31:0] word_new,
  output logic [31:0] load_data
);

  logic [3:0]  mask;
  logic [31:0] shifted;
  logic [31:0] field;
  logic [4:0]  sh_b;
  logic [4:0]  sh_h;

  assign sh_b = {lane, 3'b000};
  assign sh_h = {lane[1], 4'b0000};

  always_comb begin
    mask    = 4'b0000;
    shifted = '0;
    case (size)
      SZ_BYTE: begin
        mask    = 4'b0001 << lane;
        shifted = {24'b0, wdata[7:0]} << sh_b;
      end
      SZ_HALF: begin
        mask    = 4'b0011 << {lane[1], 1'b0};
        shifted = {16'b0, wdata[15:0]} << sh_h;
      end
      SZ_WORD: begin
        mask    = 4'b1111;
        shifted = wdata;
      end
      default: begin
        mask    = 4'b0000;
        shifted = '0;
      end
    endcase
    word_new = word_old;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) word_new[8*i +: 8] = shifted[8*i +: 8];
    end
  end

  always_comb begin
    field     = '0;
    load_data = '0;
    case (size)
      SZ_BYTE: begin
        field     = word_old >> sh_b;
        load_data = {{24{~uns & field[7]}}, field[7:0]};
      end
      SZ_HALF: begin
        field     = word_old >> sh_h;
        load_data = {{16{~uns & field[15]}}, field[15:0]};
      end
      SZ_WORD: begin
        field     = word_old;
        load_data = word_old;
      end
      default: begin
        field     = '0;
        load_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/dm_sized.sv
// Byte-addressed, word-organised data memory with sized accesses and a req/ready/ack handshake.
module dm_sized
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int LATENCY    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic                  ack,
  output logic                  err,
  output logic [31:0]           rdata
);

  localparam int   DEPTH = 1 << (ADDR_WIDTH - 2);
  localparam int   CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic FAST  = (LATENCY == 1);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("dm_sized: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 3 || ADDR_WIDTH > 16) begin : g_bad_addr_width
    $error("dm_sized: ADDR_WIDTH out of range 3..16");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("dm_sized: LATENCY out of range 1..8");
  end

  dm_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic                  l_we;
  logic [1:0]            l_size;
  logic                  l_uns;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [31:0]           l_wdata;

  logic [31:0] mem [DEPTH] = '{default: '0};

  // With LATENCY=1 the commit edge is the accept edge, so the live inputs stand in for the latch.
  logic                  in_idle;
  logic                  e_we;
  logic [1:0]            e_size;
  logic                  e_uns;
  logic [ADDR_WIDTH-1:0] e_addr;
  logic [31:0]           e_wdata;
  logic                  e_err;
  logic                  commit;
  logic [31:0]           rd_word;
  logic [31:0]           word_new;
  logic [31:0]           load_data;

  assign in_idle = (state == IDLE);
  assign e_we    = in_idle ? we    : l_we;
  assign e_size  = in_idle ? size  : l_size;
  assign e_uns   = in_idle ? uns   : l_uns;
  assign e_addr  = in_idle ? addr  : l_addr;
  assign e_wdata = in_idle ? wdata : l_wdata;
  assign e_err   = dm_misaligned(e_size, e_addr[1:0]);
  assign rd_word = mem[e_addr[ADDR_WIDTH-1:2]];

  assign commit = (in_idle && req && FAST) ||
                  ((state == BUSY) && (cnt == CNT_W'(1)));

  dm_byte_lane u_lane (
    .word_old  (rd_word),
    .wdata     (e_wdata),
    .size      (e_size),
    .lane      (e_addr[1:0]),
    .uns       (e_uns),
    .word_new  (word_new),
    .load_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst && commit && e_we && !e_err) begin
      mem[e_addr[ADDR_WIDTH-1:2]] <= word_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      cnt     <= '0;
      l_we    <= 1'b0;
      l_size  <= '0;
      l_uns   <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (req) begin
            l_we    <= we;
            l_size  <= size;
            l_uns   <= uns;
            l_addr  <= addr;
            l_wdata <= wdata;
            cnt     <= CNT_W'(LATENCY - 1);
            ready   <= 1'b0;
            state   <= FAST ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (cnt != CNT_W'(1)) cnt <= cnt - CNT_W'(1);
          else state <= DONE;
        end
        DONE: begin
          ack   <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ack   <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
      if (commit) begin
        ack <= 1'b1;
        err <= e_err;
        if (e_err) rdata <= '0;
        else if (!e_we) rdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_dm_sized.sv
// Randomized bench for dm_sized against a byte-array reference model, plus held-request timing checks.
module tb_dm_sized;

  localparam int AW  = 7;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [AW-1:0] addr;
  logic [31:0] wdata;
  logic        ready, ack, err;
  logic [31:0] rdata;

  logic        hr_req, hr_we, hr_uns;
  logic [1:0]  hr_size;
  logic [AW-1:0] hr_addr;
  logic [31:0] hr_wdata;
  logic        r1, a1, e1, r4, a4, e4;
  logic [31:0] d1, d4;
  logic        rd_v [2];
  logic        ak_v [2];

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]  mb [1 << AW];
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  dm_sized #(.ADDR_WIDTH(AW), .LATENCY(LAT), .DATA_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns), .addr(addr),
    .wdata(wdata), .ready(ready), .ack(ack), .err(err), .rdata(rdata)
  );

  dm_sized #(.ADDR_WIDTH(AW), .LATENCY(1), .DATA_WIDTH(32)) u_lat1 (
    .clk(clk), .rst(rst), .req(hr_req), .we(hr_we), .size(hr_size), .uns(hr_uns),
    .addr(hr_addr), .wdata(hr_wdata), .ready(r1), .ack(a1), .err(e1), .rdata(d1)
  );

  dm_sized #(.ADDR_WIDTH(AW), .LATENCY(4), .DATA_WIDTH(32)) u_lat4 (
    .clk(clk), .rst(rst), .req(hr_req), .we(hr_we), .size(hr_size), .uns(hr_uns),
    .addr(hr_addr), .wdata(hr_wdata), .ready(r4), .ack(a4), .err(e4), .rdata(d4)
  );

  assign rd_v[0] = r1;
  assign rd_v[1] = r4;
  assign ak_v[0] = a1;
  assign ak_v[1] = a4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_bad(input logic [1:0] sz, input logic [AW-1:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  // One complete access: predicts the result from the byte model, runs it on the DUT, compares.
  task automatic do_access(input logic w, input logic [1:0] sz, input logic u,
                           input logic [AW-1:0] a, input logic [31:0] wd,
                           input string tag, output logic [31:0] got);
    int          n, lat, t;
    logic        bad;
    logic [31:0] v;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bad = m_bad(sz, a);
    if (bad) begin
      m_rdata = 32'h0;
    end else if (w) begin
      for (int i = 0; i < n; i++) mb[int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[int'(a) + i];
      if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      m_rdata = v;
    end

    @(negedge clk);
    t = 0;
    while (ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (ack !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, bad});
    chk({tag, "_rdata"}, rdata, m_rdata);
    got = rdata;
    @(negedge clk);
    chk({tag, "_ack_once"}, {31'b0, ack}, 32'd0);
  endtask

  initial begin : main
    logic [31:0] g;
    logic [1:0]  sz;
    logic [AW-1:0] a;
    int pend [2];
    int last [2];
    int n_acc [2];
    int n_ack [2];
    int lat_v [2];
    logic exp_ack, exp_rdy;

    for (int i = 0; i < (1 << AW); i++) mb[i] = 8'h00;
    m_rdata = 32'h0;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
    hr_req = 1'b0; hr_we = 1'b0; hr_size = 2'b00; hr_uns = 1'b0; hr_addr = '0; hr_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;

    do_access(1'b1, 2'b10, 1'b0, 7'h04, 32'h12345678, "sw04", g);
    do_access(1'b0, 2'b10, 1'b0, 7'h04, 32'h0, "lw04", g);
    chk("lw04_lit", g, 32'h12345678);

    do_access(1'b1, 2'b00, 1'b0, 7'h06, 32'h00000080, "sb06", g);
    do_access(1'b0, 2'b10, 1'b0, 7'h04, 32'h0, "lw04b", g);
    chk("lw04b_lit", g, 32'h12805678);
    do_access(1'b0, 2'b00, 1'b0, 7'h06, 32'h0, "lb06", g);
    chk("lb06_lit", g, 32'hFFFFFF80);
    do_access(1'b0, 2'b00, 1'b1, 7'h06, 32'h0, "lbu06", g);
    chk("lbu06_lit", g, 32'h00000080);
    do_access(1'b0, 2'b00, 1'b0, 7'h07, 32'h0, "lb07", g);
    chk("lb07_lit", g, 32'h00000012);

    do_access(1'b1, 2'b01, 1'b0, 7'h0A, 32'h0000BEEF, "sh0a", g);
    do_access(1'b0, 2'b01, 1'b0, 7'h0A, 32'h0, "lh0a", g);
    chk("lh0a_lit", g, 32'hFFFFBEEF);
    do_access(1'b0, 2'b01, 1'b1, 7'h0A, 32'h0, "lhu0a", g);
    chk("lhu0a_lit", g, 32'h0000BEEF);
    do_access(1'b0, 2'b10, 1'b0, 7'h08, 32'h0, "lw08", g);
    chk("lw08_lit", g, 32'hBEEF0000);

    do_access(1'b1, 2'b10, 1'b0, 7'h05, 32'hDEADBEEF, "sw05_mis", g);
    do_access(1'b0, 2'b10, 1'b0, 7'h04, 32'h0, "lw04c", g);
    chk("lw04c_lit", g, 32'h12805678);
    do_access(1'b0, 2'b01, 1'b0, 7'h03, 32'h0, "lh03_mis", g);
    do_access(1'b0, 2'b11, 1'b0, 7'h08, 32'h0, "rsvd", g);

    // reset while a store is in flight
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 7'h10; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("busyrst_ack", {31'b0, ack}, 32'd0);
    chk("busyrst_ready", {31'b0, ready}, 32'd1);
    chk("busyrst_rdata", rdata, 32'h0);
    m_rdata = 32'h0;
    @(negedge clk);
    chk("busyrst_noack", {31'b0, ack}, 32'd0);
    do_access(1'b0, 2'b10, 1'b0, 7'h10, 32'h0, "lw10", g);
    chk("lw10_lit", g, 32'h0);

    // reset coinciding with a request: request must be dropped
    rst = 1'b1; req = 1'b1; we = 1'b1; size = 2'b10; addr = 7'h20; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    chk("rstreq_ready", {31'b0, ready}, 32'd1);
    @(negedge clk);
    chk("rstreq_ready2", {31'b0, ready}, 32'd1);
    chk("rstreq_ack", {31'b0, ack}, 32'd0);
    do_access(1'b0, 2'b10, 1'b0, 7'h20, 32'h0, "lw20", g);
    chk("lw20_lit", g, 32'h0);

    for (int k = 0; k < 300; k++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = AW'($urandom_range(0, (1 << AW) - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
        a[AW-1] = 1'b0;
      end
      do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(), "rnd", g);
    end

    // held request on LATENCY=1 and LATENCY=4 instances
    lat_v[0] = 1; lat_v[1] = 4;
    for (int i = 0; i < 2; i++) begin
      pend[i] = -1; last[i] = 0; n_acc[i] = 0; n_ack[i] = 0;
    end
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      hr_req = (c < 80);
      for (int i = 0; i < 2; i++) begin
        exp_ack = (pend[i] == c);
        exp_rdy = (pend[i] < 0);
        chk(i == 0 ? "hr1_ack" : "hr4_ack", {31'b0, ak_v[i]}, {31'b0, exp_ack});
        chk(i == 0 ? "hr1_ready" : "hr4_ready", {31'b0, rd_v[i]}, {31'b0, exp_rdy});
        if (ak_v[i]) n_ack[i]++;
        if (exp_ack) pend[i] = -1;
        if (rd_v[i] && hr_req) begin
          if (n_acc[i] > 0) chk(i == 0 ? "hr1_gap" : "hr4_gap", c - last[i], lat_v[i] + 1);
          last[i] = c;
          n_acc[i]++;
          pend[i] = c + lat_v[i];
        end
      end
      hr_we    = 1'($urandom_range(0, 1));
      hr_size  = 2'($urandom_range(0, 3));
      hr_uns   = 1'($urandom_range(0, 1));
      hr_addr  = AW'($urandom_range(0, (1 << AW) - 1));
      hr_wdata = $urandom();
    end
    chk("hr1_count", n_ack[0], n_acc[0]);
    chk("hr4_count", n_ack[1], n_acc[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
